// File: rtl/olivia_ctrl_pkg.sv
// Shared encodings for the multicycle LEGv8 sequencer: states, instruction
// classes, opcode constants and the alu_op / pc_src select codes.
package olivia_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE    = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_CBZ     = 3'd4,
    CL_B       = 3'd5,
    CL_ILLEGAL = 3'd6
  } class_t;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // CBZ and B are matched on a prefix only; the low bits carry offset bits.
  localparam logic [7:0] OP_CBZ_PREFIX = 8'hB4;
  localparam logic [5:0] OP_B_PREFIX   = 6'h05;

  localparam int NUM_RTYPE = 4;
  localparam logic [NUM_RTYPE*11-1:0] RTYPE_OPS = {OP_ORR, OP_AND, OP_SUB, OP_ADD};

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] PC_SEQ     = 2'b00;
  localparam logic [1:0] PC_BRANCH  = 2'b01;
  localparam logic [1:0] PC_UNCOND  = 2'b10;

  function automatic logic is_mem_class(input class_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/olivia_opcode_decoder.sv
// Combinational classifier: 11-bit LEGv8 opcode field -> instruction class.
module olivia_opcode_decoder
  import olivia_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output class_t      op_class
);

  logic [NUM_RTYPE-1:0] rtype_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RTYPE; gi++) begin : g_rtype
      assign rtype_hit[gi] = (opcode == RTYPE_OPS[gi*11 +: 11]);
    end
  endgenerate

  always_comb begin
    op_class = CL_ILLEGAL;
    if (|rtype_hit) begin
      op_class = CL_RTYPE;
    end else if (opcode == OP_LDUR) begin
      op_class = CL_LOAD;
    end else if (opcode == OP_STUR) begin
      op_class = CL_STORE;
    end else if (opcode[10:3] == OP_CBZ_PREFIX) begin
      op_class = CL_CBZ;
    end else if (opcode[10:5] == OP_B_PREFIX) begin
      op_class = CL_B;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the LEGv8 datapath with req/ready memory
// handshakes, a bounded wait timer and sticky illegal / bus-error flags.
module multicycle_sequencer
  import olivia_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg2loc,
  output logic        reg_write,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state
);

  state_t     state_reg, state_next;
  class_t     class_reg, dec_class, cur_class;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       illegal_reg, bus_err_reg;
  logic       set_illegal, set_bus_err;
  logic       wait_expired;

  logic       imem_req_raw, ir_write_raw, pc_write_raw, reg2loc_raw;
  logic       reg_write_raw, alu_src_raw, mem_read_raw, mem_write_raw;
  logic       mem_to_reg_raw, instr_done_raw;
  logic [1:0] pc_src_raw, alu_op_raw;

  olivia_opcode_decoder u_decoder (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  // In DECODE the class register is still being loaded, so use the live decode.
  assign cur_class    = (state_reg == ST_DECODE) ? dec_class : class_reg;
  assign wait_expired = (wait_cnt_reg == 8'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_FETCH;
      wait_cnt_reg <= '0;
      class_reg    <= CL_NONE;
      illegal_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == ST_DECODE) class_reg <= dec_class;
      if (set_illegal) illegal_reg <= 1'b1;
      if (set_bus_err) bus_err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    set_illegal    = 1'b0;
    set_bus_err    = 1'b0;
    imem_req_raw   = 1'b0;
    ir_write_raw   = 1'b0;
    pc_write_raw   = 1'b0;
    pc_src_raw     = PC_SEQ;
    reg2loc_raw    = 1'b0;
    reg_write_raw  = 1'b0;
    alu_src_raw    = 1'b0;
    alu_op_raw     = ALU_ADD;
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    mem_to_reg_raw = 1'b0;
    instr_done_raw = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        imem_req_raw = 1'b1;
        if (imem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          pc_src_raw   = PC_SEQ;
          state_next   = ST_DECODE;
        end else if (wait_expired) begin
          set_bus_err = 1'b1;
          state_next  = ST_HALT;
        end
      end

      ST_DECODE: begin
        reg2loc_raw = (cur_class == CL_STORE) || (cur_class == CL_CBZ);
        if (cur_class == CL_ILLEGAL) begin
          set_illegal = 1'b1;
          state_next  = ST_HALT;
        end else if (cur_class == CL_B) begin
          pc_write_raw   = 1'b1;
          pc_src_raw     = PC_UNCOND;
          instr_done_raw = 1'b1;
          state_next     = ST_FETCH;
        end else begin
          state_next = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        reg2loc_raw = (cur_class == CL_STORE) || (cur_class == CL_CBZ);
        alu_src_raw = is_mem_class(cur_class);
        case (cur_class)
          CL_RTYPE: begin
            alu_op_raw = ALU_FUNCT;
            state_next = ST_WRITEBACK;
          end
          CL_CBZ: begin
            alu_op_raw     = ALU_PASS_B;
            pc_write_raw   = alu_zero;
            pc_src_raw     = PC_BRANCH;
            instr_done_raw = 1'b1;
            state_next     = ST_FETCH;
          end
          CL_LOAD, CL_STORE: begin
            alu_op_raw = ALU_ADD;
            state_next = ST_MEM;
          end
          default: state_next = ST_HALT;
        endcase
      end

      ST_MEM: begin
        mem_read_raw  = (cur_class == CL_LOAD);
        mem_write_raw = (cur_class == CL_STORE);
        if (dmem_ready) begin
          if (cur_class == CL_LOAD) begin
            state_next = ST_WRITEBACK;
          end else begin
            instr_done_raw = 1'b1;
            state_next     = ST_FETCH;
          end
        end else if (wait_expired) begin
          set_bus_err = 1'b1;
          state_next  = ST_HALT;
        end
      end

      ST_WRITEBACK: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = (cur_class == CL_LOAD);
        instr_done_raw = 1'b1;
        state_next     = ST_FETCH;
      end

      ST_HALT: state_next = ST_HALT;

      // Unused codes fall into HALT rather than wandering.
      default: state_next = ST_HALT;
    endcase

    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg) begin
      wait_cnt_next = '0;
    end else if ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
  end

  // Every output is held low while reset is asserted, including mid-instruction.
  assign imem_req   = rst & imem_req_raw;
  assign ir_write   = rst & ir_write_raw;
  assign pc_write   = rst & pc_write_raw;
  assign pc_src     = rst ? pc_src_raw : 2'b00;
  assign reg2loc    = rst & reg2loc_raw;
  assign reg_write  = rst & reg_write_raw;
  assign alu_src    = rst & alu_src_raw;
  assign alu_op     = rst ? alu_op_raw : 2'b00;
  assign mem_read   = rst & mem_read_raw;
  assign mem_write  = rst & mem_write_raw;
  assign mem_to_reg = rst & mem_to_reg_raw;
  assign instr_done = rst & instr_done_raw;
  assign illegal    = rst & illegal_reg;
  assign bus_err    = rst & bus_err_reg;
  assign state      = rst ? state_reg : 3'd0;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: a per-instruction summary model
// feeds a queue, and a monitor compares the observed strobe profile on retire/halt.
module tb_multicycle_sequencer;

  localparam int MW        = 4;
  localparam int NEVER     = 200;
  localparam int MAX_POLL  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode;
  logic        alu_zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, ir_write, pc_write, reg2loc, reg_write, alu_src;
  logic        mem_read, mem_write, mem_to_reg, instr_done, illegal, bus_err;
  logic [1:0]  pc_src, alu_op;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg2loc    (reg2loc),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .state      (state)
  );

  // Per-instruction profile: outcome, cycle count, strobe counts and a state trace.
  typedef struct packed {
    logic [1:0]  kind;   // 0 retired, 1 illegal halt, 2 bus-error halt
    logic [7:0]  cyc;
    logic [7:0]  ireq;
    logic [7:0]  irw;
    logic [7:0]  pcw;
    logic [1:0]  pcsrc;  // OR of pc_src over the instruction
    logic [7:0]  r2l;
    logic [7:0]  rw;
    logic [7:0]  asrc;
    logic [1:0]  aop;    // OR of alu_op over the instruction
    logic [7:0]  mrd;
    logic [7:0]  mwr;
    logic [7:0]  m2r;
    logic [63:0] trace;
  } rec_t;

  rec_t        exp_q[$];
  logic [10:0] op_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;
  bit          halted = 1'b0;
  logic [1:0]  halt_flags = 2'b00;
  bit          prev_rst = 1'b0;
  rec_t        acc;

  logic [10:0] pend_op = 11'h0;
  int          pend_wi = 0;
  int          pend_wd = 0;
  logic        pend_z  = 1'b0;
  int          cur_wd  = 0;

  wire [18:0] all_outs = {imem_req, ir_write, pc_write, pc_src, reg2loc, reg_write,
                          alu_src, alu_op, mem_read, mem_write, mem_to_reg,
                          instr_done, illegal, bus_err, state};
  wire [13:0] strobes = all_outs[18:5];

  function automatic rec_t step(input rec_t r, input logic [2:0] s);
    r.trace = {r.trace[60:0], s};
    r.cyc   = r.cyc + 8'd1;
    return r;
  endfunction

  // Expected profile from the instruction class, memory waits and zero flag.
  function automatic rec_t model(input logic [10:0] op, input int wi, input int wd,
                                 input logic z);
    rec_t r;
    int   cls; // 0 R-type, 1 load, 2 store, 3 cbz, 4 b, 5 illegal
    r = '0;
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) cls = 0;
    else if (op == 11'h7C2) cls = 1;
    else if (op == 11'h7C0) cls = 2;
    else if (op[10:3] == 8'hB4) cls = 3;
    else if (op[10:5] == 6'h05) cls = 4;
    else cls = 5;

    if (wi >= MW) begin
      for (int i = 0; i < MW; i++) r = step(r, 3'd0);
      r.ireq = 8'(MW);
      r.kind = 2'd2;
      return r;
    end
    for (int i = 0; i <= wi; i++) r = step(r, 3'd0);
    r.ireq = 8'(wi + 1);
    r.irw  = 8'd1;
    r.pcw  = 8'd1;
    r = step(r, 3'd1);

    case (cls)
      0: begin
        r = step(r, 3'd2);
        r = step(r, 3'd4);
        r.aop = 2'b10;
        r.rw  = 8'd1;
      end
      1, 2: begin
        r = step(r, 3'd2);
        r.asrc = 8'd1;
        if (cls == 2) r.r2l = 8'd2;
        if (wd >= MW) begin
          for (int i = 0; i < MW; i++) r = step(r, 3'd3);
          if (cls == 1) r.mrd = 8'(MW); else r.mwr = 8'(MW);
          r.kind = 2'd2;
        end else begin
          for (int i = 0; i <= wd; i++) r = step(r, 3'd3);
          if (cls == 1) r.mrd = 8'(wd + 1); else r.mwr = 8'(wd + 1);
          if (cls == 1) begin
            r = step(r, 3'd4);
            r.rw  = 8'd1;
            r.m2r = 8'd1;
          end
        end
      end
      3: begin
        r = step(r, 3'd2);
        r.r2l   = 8'd2;
        r.aop   = 2'b01;
        r.pcsrc = 2'b01;
        r.pcw   = r.pcw + {7'd0, z};
      end
      4: begin
        r.pcw   = 8'd2;
        r.pcsrc = 2'b10;
      end
      default: r.kind = 2'd1;
    endcase
    return r;
  endfunction

  task automatic finalize(input logic [1:0] kind);
    rec_t        e;
    logic [10:0] o;
    acc.kind = kind;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_end: got kind=%0d cyc=%0d, required no transaction pending",
               kind, acc.cyc);
    end else begin
      e = exp_q.pop_front();
      o = op_q.pop_front();
      if (acc !== e) begin
        errors++;
        $display("FAIL txn op=%h: got kind=%0d cyc=%0d prof=%h, required kind=%0d cyc=%0d prof=%h",
                 o, acc.kind, acc.cyc, acc, e.kind, e.cyc, e);
      end else begin
        $display("txn op=%h kind=%0d cyc=%0d ok", o, acc.kind, acc.cyc);
      end
    end
    n_done++;
    acc = '0;
  endtask

  // Monitor: samples on the falling edge, away from all stimulus changes.
  initial begin
    acc = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (all_outs !== 19'd0) begin
          errors++;
          $display("FAIL reset_outputs: got %h, required 0", all_outs);
        end
        exp_q.delete();
        op_q.delete();
        acc      = '0;
        halted   = 1'b0;
        prev_rst = 1'b0;
      end else begin
        if (!prev_rst) begin
          checks++;
          if (state !== 3'd0 || illegal !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got state=%0d illegal=%b bus_err=%b, required 0 0 0",
                     state, illegal, bus_err);
          end
        end
        prev_rst = 1'b1;
        if (state !== 3'd5) begin
          acc       = step(acc, state);
          acc.ireq  = acc.ireq + {7'd0, imem_req};
          acc.irw   = acc.irw + {7'd0, ir_write};
          acc.pcw   = acc.pcw + {7'd0, pc_write};
          acc.pcsrc = acc.pcsrc | pc_src;
          acc.r2l   = acc.r2l + {7'd0, reg2loc};
          acc.rw    = acc.rw + {7'd0, reg_write};
          acc.asrc  = acc.asrc + {7'd0, alu_src};
          acc.aop   = acc.aop | alu_op;
          acc.mrd   = acc.mrd + {7'd0, mem_read};
          acc.mwr   = acc.mwr + {7'd0, mem_write};
          acc.m2r   = acc.m2r + {7'd0, mem_to_reg};
          if (instr_done) finalize({bus_err, illegal});
        end else begin
          checks++;
          if (strobes !== 14'd0 || (halted && {bus_err, illegal} !== halt_flags)) begin
            errors++;
            $display("FAIL halt_outputs: got strobes=%h flags=%b, required strobes=0 flags=%b",
                     strobes, {bus_err, illegal}, halted ? halt_flags : {bus_err, illegal});
          end
          if (!halted) begin
            halted     = 1'b1;
            halt_flags = {bus_err, illegal};
            finalize({bus_err, illegal});
          end
        end
      end
    end
  end

  // Memory responder and instruction register: acts after each rising edge.
  initial begin
    int icnt;
    int dcnt;
    bit grant;
    icnt = 0; dcnt = 0; grant = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    opcode     = 11'h0;
    alu_zero   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (grant) begin
        opcode   = pend_op;
        alu_zero = pend_z;
        cur_wd   = pend_wd;
      end
      if (imem_req) begin
        imem_ready = (icnt >= pend_wi);
        icnt++;
      end else begin
        imem_ready = 1'b0;
        icnt = 0;
      end
      grant = imem_ready;
      if (mem_read || mem_write) begin
        dmem_ready = (dcnt >= cur_wd);
        dcnt++;
      end else begin
        dmem_ready = 1'b0;
        dcnt = 0;
      end
    end
  end

  task automatic hold_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [10:0] op, input int wi, input int wd, input logic z);
    int target;
    int k;
    pend_op = op;
    pend_wi = wi;
    pend_wd = wd;
    pend_z  = z;
    exp_q.push_back(model(op, wi, wd, z));
    op_q.push_back(op);
    if (!rst) begin
      @(posedge clk);
      #1 rst = 1'b1;
    end
    target = n_done + 1;
    k = 0;
    while (n_done < target && k < MAX_POLL) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_done < target) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%h: got no retire/halt in %0d cycles, required one", op, MAX_POLL);
      hold_reset();
    end else if (halted) begin
      hold_reset();
    end
  endtask

  initial begin
    logic [10:0] op;
    int          wi;
    int          wd;
    int          sel;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    run_instr(11'h458, 0, 0, 1'b0);      // ADD, zero wait
    run_instr(11'h7C2, 0, 3, 1'b0);      // LDUR, dmem ready after 3 waits
    run_instr(11'hB40, 0, 0, 1'b1);      // CBZ taken
    run_instr(11'hB40, 0, 0, 1'b0);      // CBZ not taken
    run_instr(11'h0A0, 0, 0, 1'b0);      // B
    run_instr(11'h000, 0, 0, 1'b0);      // illegal -> halt
    run_instr(11'h458, NEVER, 0, 1'b0);  // fetch timeout -> bus error
    run_instr(11'h458, MW - 1, 0, 1'b0); // ready on the last allowed cycle
    run_instr(11'h7C0, 1, 2, 1'b0);      // STUR with waits
    run_instr(11'h7C0, 0, MW - 1, 1'b0); // store ready on last allowed cycle
    run_instr(11'h7C2, 0, NEVER, 1'b0);  // data timeout -> bus error
    run_instr(11'h658, 2, 0, 1'b0);
    run_instr(11'h450, 0, 0, 1'b0);
    run_instr(11'h550, 1, 0, 1'b0);
    run_instr(11'h0BF, 0, 0, 1'b0);
    run_instr(11'hB47, 0, 0, 1'b1);

    // Abort a load mid-MEM with reset; nothing may retire for it.
    pend_op = 11'h7C2; pend_wi = 0; pend_wd = 3; pend_z = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    run_instr(11'h458, 0, 0, 1'b0);

    for (int t = 0; t < 50; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: op = 11'h458;
        1: op = 11'h658;
        2: op = 11'h450;
        3: op = 11'h550;
        4: op = 11'h7C2;
        5: op = 11'h7C0;
        6: op = {8'hB4, 3'($urandom)};
        7: op = {6'h05, 5'($urandom)};
        default: op = 11'($urandom);
      endcase
      wi = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, MW - 1);
      wd = ($urandom_range(0, 10) == 0) ? NEVER : $urandom_range(0, MW - 1);
      run_instr(op, wi, wd, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
